// File: rtl/data_compare_pkg.sv
// Shared definitions for the data_compare_pipe block: result-bit positions,
// the one-hot result type and a helper that builds a result from flags.
package data_compare_pkg;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  typedef logic [2:0] cmp_res_t;

  // Build a one-hot result; equality is whatever is neither greater nor less.
  function automatic cmp_res_t make_res(input logic gt, input logic lt);
    cmp_res_t r;
    r = 3'b000;
    if (gt) begin
      r[CMP_GT] = 1'b1;
    end else if (lt) begin
      r[CMP_LT] = 1'b1;
    end else begin
      r[CMP_EQ] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_compare_pipe_cmp_core.sv
// cmp_core: combinational magnitude compare of two WIDTH-bit operands,
// unsigned or two's complement depending on SIGNED. Output is always one-hot.
module cmp_core
  import data_compare_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  logic gt;
  logic lt;

  // Greater/less flags in the selected number interpretation.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (SIGNED != 0) begin
      gt = ($signed(a) > $signed(b));
      lt = ($signed(a) < $signed(b));
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
  end

  assign res = make_res(gt, lt);

endmodule

// File: rtl/data_compare_pipe.sv
// data_compare_pipe: two-stage valid/ready compare pipeline. Stage 1 holds the
// operand pair, stage 2 holds the registered one-hot compare result.
// Optional per-outcome saturating statistics counters are built only when the
// macro DATA_COMPARE_STATS_EN is defined; otherwise they read zero and iClear
// is ignored.
module data_compare_pipe
  import data_compare_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iClear,
  output logic             oValid,
  input  logic             iReady,
  output logic [2:0]       oData,
  output logic [CNT_W-1:0] oGtCnt,
  output logic [CNT_W-1:0] oEqCnt,
  output logic [CNT_W-1:0] oLtCnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  cmp_res_t         s2_data;
  cmp_res_t         cmp_res;
  logic             s2_advance;
  logic             in_fire;

  // Stage 2 may take a new value when empty or when its result leaves.
  assign s2_advance = !s2_valid || iReady;
  assign oReady     = !s1_valid || s2_advance;
  assign in_fire    = iValid && oReady;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp_core (
    .a   (s1_a),
    .b   (s1_b),
    .res (cmp_res)
  );

  // Stage 1: capture an accepted operand pair, empty when it moves on.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= {WIDTH{1'b0}};
      s1_b     <= {WIDTH{1'b0}};
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= iData_a;
      s1_b     <= iData_b;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // Stage 2: register the compare result; data is forced to zero when empty.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= 3'b000;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      s2_data  <= s1_valid ? cmp_res : 3'b000;
    end else begin
      s2_valid <= s2_valid;
      s2_data  <= s2_data;
    end
  end

  assign oValid = s2_valid;
  assign oData  = s2_data;

`ifdef DATA_COMPARE_STATS_EN

  logic             out_fire;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;

  assign out_fire = s2_valid && iReady;

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Per-outcome delivery counters; clear wins but still records a same-cycle delivery.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      gt_cnt <= {CNT_W{1'b0}};
      eq_cnt <= {CNT_W{1'b0}};
      lt_cnt <= {CNT_W{1'b0}};
    end else if (iClear) begin
      gt_cnt <= {{(CNT_W-1){1'b0}}, out_fire & s2_data[CMP_GT]};
      eq_cnt <= {{(CNT_W-1){1'b0}}, out_fire & s2_data[CMP_EQ]};
      lt_cnt <= {{(CNT_W-1){1'b0}}, out_fire & s2_data[CMP_LT]};
    end else begin
      gt_cnt <= (out_fire && s2_data[CMP_GT]) ? sat_inc(gt_cnt) : gt_cnt;
      eq_cnt <= (out_fire && s2_data[CMP_EQ]) ? sat_inc(eq_cnt) : eq_cnt;
      lt_cnt <= (out_fire && s2_data[CMP_LT]) ? sat_inc(lt_cnt) : lt_cnt;
    end
  end

  assign oGtCnt = gt_cnt;
  assign oEqCnt = eq_cnt;
  assign oLtCnt = lt_cnt;

`else

  logic clear_unused;

  assign clear_unused = iClear;
  assign oGtCnt       = {CNT_W{1'b0}};
  assign oEqCnt       = {CNT_W{1'b0}};
  assign oLtCnt       = {CNT_W{1'b0}};

`endif

endmodule

// File: tb/tb_data_compare_pipe.sv
// Bench for data_compare_pipe: an unsigned and a signed instance share the same
// stimulus; a queue-based reference model predicts results, handshake and counters.
module tb_data_compare_pipe;

`ifdef DATA_COMPARE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, clear, out_ready;
  logic [7:0] a, b;
  logic       u_ready, u_valid, s_ready, s_valid;
  logic [2:0] u_data, s_data;
  logic [3:0] u_gt, u_eq, u_lt, s_gt, s_eq, s_lt;
  logic [3:0] ucv [3];
  logic [3:0] scv [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  bit         head_out;
  int         ucnt [3];
  int         scnt [3];

  logic [7:0] da [4] = '{8'hF0, 8'h55, 8'hCC, 8'h80};
  logic [7:0] db [4] = '{8'h0F, 8'hAA, 8'hCC, 8'h7F};
  logic [2:0] eu [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] es [4] = '{3'b001, 3'b100, 3'b010, 3'b001};

  assign ucv[2] = u_gt; assign ucv[1] = u_eq; assign ucv[0] = u_lt;
  assign scv[2] = s_gt; assign scv[1] = s_eq; assign scv[0] = s_lt;

  always #5 clk = ~clk;

  data_compare_pipe #(.WIDTH(8), .SIGNED(0), .CNT_W(4)) u_dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(in_valid), .oReady(u_ready),
    .iData_a(a), .iData_b(b), .iClear(clear), .oValid(u_valid),
    .iReady(out_ready), .oData(u_data), .oGtCnt(u_gt), .oEqCnt(u_eq), .oLtCnt(u_lt));

  data_compare_pipe #(.WIDTH(8), .SIGNED(1), .CNT_W(4)) s_dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(in_valid), .oReady(s_ready),
    .iData_a(a), .iData_b(b), .iClear(clear), .oValid(s_valid),
    .iReady(out_ready), .oData(s_data), .oGtCnt(s_gt), .oEqCnt(s_eq), .oLtCnt(s_lt));

  function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    if (sgn) begin
      if (ix > 127) ix = ix - 256;
      if (iy > 127) iy = iy - 256;
    end
    if (ix > iy) return 3'b100;
    if (ix == iy) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int res_idx(input logic [2:0] r);
    if (r[2]) return 2;
    if (r[1]) return 1;
    return 0;
  endfunction

  function automatic bit exp_valid();
    return (qa.size() > 0) && head_out;
  endfunction

  // at most two pairs in flight; a full pipe frees a slot only if the result leaves
  function automatic bit exp_ready();
    return (qa.size() < 2) || out_ready;
  endfunction

  function automatic logic [2:0] exp_data(input bit sgn);
    if (!exp_valid()) return 3'b000;
    return ref_cmp(qa[0], qb[0], sgn);
  endfunction

  function automatic logic [3:0] exp_cnt(input bit sgn, input int k);
    if (!STATS) return 4'd0;
    return sgn ? 4'(scnt[k]) : 4'(ucnt[k]);
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    head_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ucnt[k] = 0;
      scnt[k] = 0;
    end
  endtask

  // one clock edge: update the model from the handshake seen before the edge
  task automatic advance();
    bit of, inf;
    int ku, ks;
    of  = exp_valid() && out_ready;
    inf = in_valid && exp_ready();
    ku = 0;
    ks = 0;
    if (of) begin
      ku = res_idx(ref_cmp(qa[0], qb[0], 1'b0));
      ks = res_idx(ref_cmp(qa[0], qb[0], 1'b1));
    end
    if (clear) begin
      for (int k = 0; k < 3; k++) begin
        ucnt[k] = 0;
        scnt[k] = 0;
      end
    end
    if (of) begin
      ucnt[ku] = (ucnt[ku] < 15) ? ucnt[ku] + 1 : 15;
      scnt[ks] = (scnt[ks] < 15) ? scnt[ks] + 1 : 15;
    end
    @(posedge clk);
    #1;
    if (of) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    head_out = (qa.size() > 0);
    if (inf) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (u_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", u_valid); else pass_cnt++;
    total_cnt++; if (u_data !== 3'b000) $display("FAIL reset_data: got %b expected 000", u_data); else pass_cnt++;
    total_cnt++; if (u_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", u_ready); else pass_cnt++;
    total_cnt++; if (s_valid !== 1'b0) $display("FAIL reset_s_valid: got %0b expected 0", s_valid); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (ucv[k] !== 4'd0) $display("FAIL reset_cnt%0d: got %0d expected 0", k, ucv[k]); else pass_cnt++;
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = da[i]; b = db[i];
      #1;
      advance();
      in_valid = 1'b0;
      #1;
      total_cnt++; if (u_valid !== 1'b0) $display("FAIL dir_early_valid[%0d]: got %0b expected 0", i, u_valid); else pass_cnt++;
      advance();
      total_cnt++; if (u_valid !== 1'b1) $display("FAIL dir_valid[%0d]: got %0b expected 1", i, u_valid); else pass_cnt++;
      total_cnt++; if (u_data !== eu[i]) $display("FAIL dir_unsigned[%0d]: got %b expected %b", i, u_data, eu[i]); else pass_cnt++;
      total_cnt++; if (s_data !== es[i]) $display("FAIL dir_signed[%0d]: got %b expected %b", i, s_data, es[i]); else pass_cnt++;
      advance();
      total_cnt++; if (u_data !== 3'b000) $display("FAIL dir_drained[%0d]: got %b expected 000", i, u_data); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [2:0] first, want;
    int sent, got;
    sent = 0;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    first = ref_cmp(pa[0], pb[0], 1'b0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid  = (sent < 3);
      a         = pa[(sent < 3) ? sent : 0];
      b         = pb[(sent < 3) ? sent : 0];
      out_ready = !(cyc >= 2 && cyc < 6);
      #1;
      total_cnt++; if (u_valid !== exp_valid()) $display("FAIL b2b_valid c%0d: got %0b expected %0b", cyc, u_valid, exp_valid()); else pass_cnt++;
      total_cnt++; if (u_ready !== exp_ready()) $display("FAIL b2b_ready c%0d: got %0b expected %0b", cyc, u_ready, exp_ready()); else pass_cnt++;
      if (cyc >= 2 && cyc < 6) begin
        total_cnt++; if (u_data !== first) $display("FAIL b2b_hold c%0d: got %b expected %b", cyc, u_data, first); else pass_cnt++;
        total_cnt++; if (u_ready !== 1'b0) $display("FAIL b2b_full c%0d: got %0b expected 0", cyc, u_ready); else pass_cnt++;
      end
      if (exp_valid() && out_ready && got < 3) begin
        want = ref_cmp(pa[got], pb[got], 1'b0);
        total_cnt++; if (u_data !== want) $display("FAIL b2b_order%0d: got %b expected %b", got, u_data, want); else pass_cnt++;
        got++;
      end
      if (in_valid && exp_ready()) sent++;
      advance();
    end
    in_valid = 1'b0;
    total_cnt++; if (got !== 3) $display("FAIL b2b_count: got %0d expected 3", got); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 39) == 0);
      a         = 8'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      #1;
      total_cnt++; if (u_valid !== exp_valid()) $display("FAIL rnd_u_valid c%0d: got %0b expected %0b", cyc, u_valid, exp_valid()); else pass_cnt++;
      total_cnt++; if (u_data !== exp_data(1'b0)) $display("FAIL rnd_u_data c%0d: got %b expected %b", cyc, u_data, exp_data(1'b0)); else pass_cnt++;
      total_cnt++; if (u_ready !== exp_ready()) $display("FAIL rnd_u_ready c%0d: got %0b expected %0b", cyc, u_ready, exp_ready()); else pass_cnt++;
      total_cnt++; if (s_valid !== exp_valid()) $display("FAIL rnd_s_valid c%0d: got %0b expected %0b", cyc, s_valid, exp_valid()); else pass_cnt++;
      total_cnt++; if (s_data !== exp_data(1'b1)) $display("FAIL rnd_s_data c%0d: got %b expected %b", cyc, s_data, exp_data(1'b1)); else pass_cnt++;
      total_cnt++; if (s_ready !== exp_ready()) $display("FAIL rnd_s_ready c%0d: got %0b expected %0b", cyc, s_ready, exp_ready()); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
        total_cnt++; if (ucv[k] !== exp_cnt(1'b0, k)) $display("FAIL rnd_u_cnt%0d c%0d: got %0d expected %0d", k, cyc, ucv[k], exp_cnt(1'b0, k)); else pass_cnt++;
        total_cnt++; if (scv[k] !== exp_cnt(1'b1, k)) $display("FAIL rnd_s_cnt%0d c%0d: got %0d expected %0d", k, cyc, scv[k], exp_cnt(1'b1, k)); else pass_cnt++;
      end
      advance();
    end
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin #1; advance(); end
  endtask

  task automatic test_counters();
    out_ready = 1'b1; in_valid = 1'b0; clear = 1'b1;
    #1; advance();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = a;
      #1; advance();
    end
    in_valid = 1'b0;
    repeat (3) begin #1; advance(); end
    #1;
    total_cnt++; if (u_eq !== (STATS ? 4'd15 : 4'd0)) $display("FAIL cnt_eq_sat: got %0d expected %0d", u_eq, STATS ? 15 : 0); else pass_cnt++;
    total_cnt++; if (s_eq !== (STATS ? 4'd15 : 4'd0)) $display("FAIL cnt_s_eq_sat: got %0d expected %0d", s_eq, STATS ? 15 : 0); else pass_cnt++;
    total_cnt++; if (u_gt !== 4'd0) $display("FAIL cnt_gt_zero: got %0d expected 0", u_gt); else pass_cnt++;
    in_valid = 1'b1; a = 8'hF0; b = 8'h0F;
    #1; advance();
    in_valid = 1'b0;
    #1; advance();
    clear = 1'b1;
    #1;
    total_cnt++; if (u_valid !== 1'b1) $display("FAIL cnt_gt_valid: got %0b expected 1", u_valid); else pass_cnt++;
    advance();
    clear = 1'b0;
    #1;
    total_cnt++; if (u_gt !== (STATS ? 4'd1 : 4'd0)) $display("FAIL clr_u_gt: got %0d expected %0d", u_gt, STATS ? 1 : 0); else pass_cnt++;
    total_cnt++; if (u_eq !== 4'd0) $display("FAIL clr_u_eq: got %0d expected 0", u_eq); else pass_cnt++;
    total_cnt++; if (u_lt !== 4'd0) $display("FAIL clr_u_lt: got %0d expected 0", u_lt); else pass_cnt++;
    total_cnt++; if (s_lt !== (STATS ? 4'd1 : 4'd0)) $display("FAIL clr_s_lt: got %0d expected %0d", s_lt, STATS ? 1 : 0); else pass_cnt++;
    total_cnt++; if (s_eq !== 4'd0) $display("FAIL clr_s_eq: got %0d expected 0", s_eq); else pass_cnt++;
    total_cnt++; if (s_gt !== 4'd0) $display("FAIL clr_s_gt: got %0d expected 0", s_gt); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      #1; advance();
    end
    in_valid = 1'b0;
    #1;
    total_cnt++; if (u_valid !== 1'b1) $display("FAIL mid_loaded: got %0b expected 1", u_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (u_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b expected 0", u_valid); else pass_cnt++;
    total_cnt++; if (u_data !== 3'b000) $display("FAIL mid_rst_data: got %b expected 000", u_data); else pass_cnt++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (u_ready !== 1'b1) $display("FAIL mid_rel_ready: got %0b expected 1", u_ready); else pass_cnt++;
    for (int cyc = 0; cyc < 4; cyc++) begin
      advance();
      total_cnt++; if (u_valid !== 1'b0) $display("FAIL mid_stale c%0d: got %0b expected 0", cyc, u_valid); else pass_cnt++;
      total_cnt++; if (s_valid !== 1'b0) $display("FAIL mid_s_stale c%0d: got %0b expected 0", cyc, s_valid); else pass_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (ucv[k] !== 4'd0) $display("FAIL mid_cnt%0d: got %0d expected 0", k, ucv[k]); else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_counters();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
